// File: rtl/can_ctrl_pkg.sv
// can_ctrl_pkg: shared state encodings and widths for the CAN host controller.
package can_ctrl_pkg;
  localparam int PM_ADDR_W = 7;
  localparam int PM_WORD_W = 20;
  localparam int ROW_ADDR_W = 4;
  localparam int ROW_W = 512;
  localparam int WORD_W = 32;
  localparam int WORDS_PER_ROW = 16;
  localparam int WORD_IDX_W = 4;
  typedef enum logic [2:0] {IDLE, LOAD_PROG, LOAD_DATA, RUN, DRAIN, DONE} ctrlState_t;
  typedef enum logic [1:0] {DR_FETCH, DR_CAP, DR_EMIT} drainPhase_t;
endpackage

// File: rtl/can_row_serdes.sv
// can_row_serdes: assembles 32-bit beats into a 512-bit row and serialises a captured row back to 32-bit words.
module can_row_serdes
  import can_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wrEn,
  input  logic [WORD_IDX_W-1:0] wrIdx,
  input  logic [WORD_W-1:0]     wrData,
  input  logic                  capEn,
  input  logic [ROW_W-1:0]      capData,
  input  logic [WORD_IDX_W-1:0] rdIdx,
  output logic [ROW_W-1:0]      asmRow,
  output logic [WORD_W-1:0]     rdWord
);
  logic [ROW_W-1:0] rowReg;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      asmRow <= '0;
      rowReg <= '0;
    end else begin
      if (wrEn) asmRow[wrIdx*WORD_W +: WORD_W] <= wrData;
      if (capEn) rowReg <= capData;
    end
  end
  assign rdWord = rowReg[rdIdx*WORD_W +: WORD_W];
endmodule

// File: rtl/can_host_ctrl.sv
// can_host_ctrl: loads program/data memories from a host stream, runs the core, drains results.
// Optional run watchdog enabled by defining CAN_HOST_CTRL_TIMEOUT_EN.
module can_host_ctrl
  import can_ctrl_pkg::*;
#(
  parameter int PROG_DEPTH = 128,
  parameter int DATA_ROWS = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            prog_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_W-1:0]     out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  core_take,
  input  logic                  core_halted,
  output logic                  pm_write_en,
  output logic [PM_ADDR_W-1:0]  pm_write_addr,
  output logic [PM_WORD_W-1:0]  pm_write_data,
  output logic                  dm_write_en,
  output logic [ROW_ADDR_W-1:0] dm_write_addr,
  output logic [ROW_W-1:0]      dm_write_data,
  output logic [ROW_ADDR_W-1:0] dm_read_addr,
  input  logic [ROW_W-1:0]      dm_read_data
);
  ctrlState_t state, nextState;
  drainPhase_t drPh;
  logic [7:0] progLen, lenClamp;
  logic [PM_ADDR_W-1:0] pmAddr;
  logic [ROW_ADDR_W-1:0] rowCnt;
  logic [WORD_IDX_W-1:0] wordCnt;
  logic [1:0] runPh;
  logic rowFull, inBeat, outBeat, lastProg, lastRow, lastWord, halted, tmoHit;
  logic [ROW_W-1:0] asmRow;
  logic [WORD_W-1:0] rdWord;

  assign lenClamp = prog_len > 8'(PROG_DEPTH) ? 8'(PROG_DEPTH) : prog_len;
  assign inBeat = in_valid && in_ready;
  assign outBeat = out_valid && out_ready;
  assign lastProg = {1'b0, pmAddr} == progLen - 8'd1;
  assign lastRow = rowCnt == ROW_ADDR_W'(DATA_ROWS - 1);
  assign lastWord = wordCnt == WORD_IDX_W'(WORDS_PER_ROW - 1);
  // Halt is only honoured once the take cycle and the one after it have passed.
  assign halted = state == RUN && runPh == 2'd2 && core_halted;

`ifdef CAN_HOST_CTRL_TIMEOUT_EN
  logic [15:0] tmoCnt;
  logic errFlag;
  assign tmoHit = state == RUN && tmoCnt == 16'(TIMEOUT_CYCLES);
  assign error = done && errFlag;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmoCnt <= '0;
      errFlag <= 1'b0;
    end else begin
      tmoCnt <= state == RUN ? tmoCnt + 16'd1 : 16'd0;
      if (state == IDLE) errFlag <= 1'b0;
      else if (tmoHit && !halted) errFlag <= 1'b1;
    end
  end
`else
  assign tmoHit = 1'b0;
  assign error = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:      nextState = !start ? IDLE : lenClamp != 8'd0 ? LOAD_PROG : LOAD_DATA;
      LOAD_PROG: nextState = inBeat && lastProg ? LOAD_DATA : LOAD_PROG;
      LOAD_DATA: nextState = rowFull && lastRow ? RUN : LOAD_DATA;
      RUN:       nextState = halted ? DRAIN : tmoHit ? DONE : RUN;
      DRAIN:     nextState = outBeat && lastWord && lastRow ? DONE : DRAIN;
      DONE:      nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      progLen <= '0;
      pmAddr <= '0;
      rowCnt <= '0;
      wordCnt <= '0;
      rowFull <= 1'b0;
      runPh <= '0;
      drPh <= DR_FETCH;
    end else begin
      if (state == IDLE && start) begin
        progLen <= lenClamp;
        pmAddr <= '0;
        rowCnt <= '0;
        wordCnt <= '0;
        rowFull <= 1'b0;
        runPh <= '0;
      end
      if (state == LOAD_PROG && inBeat && !lastProg) pmAddr <= pmAddr + 1'b1;
      if (state == LOAD_DATA) begin
        if (inBeat) begin
          wordCnt <= wordCnt + 1'b1;
          rowFull <= lastWord;
        end
        if (rowFull) begin
          rowFull <= 1'b0;
          if (!lastRow) rowCnt <= rowCnt + 1'b1;
        end
      end
      if (state == RUN) begin
        if (runPh != 2'd2) runPh <= runPh + 2'd1;
        if (halted) begin
          rowCnt <= '0;
          wordCnt <= '0;
          drPh <= DR_FETCH;
        end
      end
      if (state == DRAIN) begin
        if (drPh == DR_FETCH) drPh <= DR_CAP;
        else if (drPh == DR_CAP) drPh <= DR_EMIT;
        else if (outBeat) begin
          wordCnt <= wordCnt + 1'b1;
          if (lastWord && !lastRow) begin
            rowCnt <= rowCnt + 1'b1;
            drPh <= DR_FETCH;
          end
        end
      end
    end
  end

  can_row_serdes u_serdes (
    .clock  (clock),
    .reset  (reset),
    .wrEn   (state == LOAD_DATA && inBeat),
    .wrIdx  (wordCnt),
    .wrData (in_data),
    .capEn  (state == DRAIN && drPh == DR_CAP),
    .capData(dm_read_data),
    .rdIdx  (wordCnt),
    .asmRow (asmRow),
    .rdWord (rdWord)
  );

  // The row write cycle holds off the host so the assembly register is stable.
  assign in_ready = state == LOAD_PROG || (state == LOAD_DATA && !rowFull);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign core_take = state == RUN && runPh == 2'd0;
  assign pm_write_en = state == LOAD_PROG && in_valid;
  assign pm_write_addr = pmAddr;
  assign pm_write_data = pm_write_en ? in_data[PM_WORD_W-1:0] : '0;
  assign dm_write_en = state == LOAD_DATA && rowFull;
  assign dm_write_addr = rowCnt;
  assign dm_write_data = asmRow;
  assign dm_read_addr = rowCnt;
  assign out_valid = state == DRAIN && drPh == DR_EMIT;
  assign out_data = rdWord;
endmodule

// File: tb/tb_can_host_ctrl.sv
// tb_can_host_ctrl: directed bench for can_host_ctrl with behavioural program/data memories.
module tb_can_host_ctrl;
  logic clock = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0, core_halted = 1'b0;
  logic [7:0] prog_len = '0;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid, busy, done, error, core_take, pm_write_en, dm_write_en;
  logic [31:0] out_data;
  logic [6:0] pm_write_addr;
  logic [19:0] pm_write_data;
  logic [3:0] dm_write_addr, dm_read_addr;
  logic [511:0] dm_write_data, dmRdData;
  logic [19:0] pm [128];
  logic [511:0] dm [16];
  int checks = 0, errors = 0, pmWrites = 0, dmWrites = 0, takes = 0, readyClash = 0;

  can_host_ctrl #(.TIMEOUT_CYCLES(20)) dut (
    .clock(clock), .reset(reset), .start(start), .prog_len(prog_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .error(error), .core_take(core_take), .core_halted(core_halted),
    .pm_write_en(pm_write_en), .pm_write_addr(pm_write_addr), .pm_write_data(pm_write_data),
    .dm_write_en(dm_write_en), .dm_write_addr(dm_write_addr), .dm_write_data(dm_write_data),
    .dm_read_addr(dm_read_addr), .dm_read_data(dmRdData)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pm_write_en) begin pm[pm_write_addr] <= pm_write_data; pmWrites++; end
    if (dm_write_en) begin dm[dm_write_addr] <= dm_write_data; dmWrites++; end
    if (dm_write_en && in_ready) readyClash++;
    if (core_take) takes++;
    dmRdData <= dm[dm_read_addr];
  end

  task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [511:0] rowExp(logic [31:0] base, int r);
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = base + 32'(16*r + k);
    return v;
  endfunction

  task automatic sendBeat(logic [31:0] d);
    bit acc;
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    do begin
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 50);
    if (!acc) check("beat_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic startJob(logic [7:0] len);
    prog_len = len;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic loadData(logic [31:0] base);
    for (int i = 0; i < 256; i++) sendBeat(base + 32'(i));
  endtask

  task automatic runDrain(logic [31:0] base, bit toggle);
    int n = 0, cyc = 0, bad = 0, stall = 0;
    bit pend = 1'b0;
    logic [31:0] prev = '0;
    while (!core_take && cyc < 100) begin step(); cyc++; end
    check("take_seen", core_take, 1);
    step(); check("take_once", core_take, 0);
    step(); step(); step();
    check("no_valid_early", out_valid, 0);
    step();
    check("valid_on_time", out_valid, 1);
    cyc = 0;
    while (!done && cyc < 3000) begin
      out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (pend && (!out_valid || out_data !== prev)) stall++;
      if (out_valid && out_ready) begin
        if (out_data !== base + 32'(n)) bad++;
        n++;
        pend = 1'b0;
      end else begin
        pend = out_valid;
        prev = out_data;
      end
      step();
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_count", n, 256);
    check("drain_order", bad, 0);
    check("drain_stable", stall, 0);
    check("done_pulse", done, 1);
    check("error_low", error, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("done_once", done, 0);
    check("start_in_done_ignored", busy, 0);
  endtask

  initial begin
    int dmBefore, pmBefore;
    start = 1'b1; in_valid = 1'b1; in_data = '1; prog_len = 8'd5;
    repeat (3) step();
    check("rst_ctrl", {busy, done, error, in_ready, out_valid, core_take, pm_write_en, dm_write_en}, 0);
    check("rst_pm", {pm_write_addr, pm_write_data}, 0);
    check("rst_dm", {dm_write_addr, dm_read_addr, out_data}, 0);
    check("rst_asm", dm_write_data, 0);
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    reset = 1'b1;
    step();
    check("idle_busy", busy, 0);

    core_halted = 1'b1;
    startJob(8'd3);
    check("load_prog_busy", busy, 1);
    start = 1'b1;
    sendBeat(32'hFFFAAAAA);
    sendBeat(32'hABC12345);
    sendBeat(32'hFFFFFFFF);
    start = 1'b0;
    check("pm_writes", pmWrites, 3);
    check("pm0", pm[0], 20'hAAAAA);
    check("pm1", pm[1], 20'h12345);
    check("pm2", pm[2], 20'hFFFFF);
    loadData(32'h0);
    runDrain(32'h0, 1'b1);
    check("dm_writes", dmWrites, 16);
    check("ready_clash", readyClash, 0);
    check("takes", takes, 1);
    check("dm_row0", dm[0], rowExp(32'h0, 0));
    check("dm_row7", dm[7], rowExp(32'h0, 7));
    check("dm_row15", dm[15], rowExp(32'h0, 15));

    startJob(8'd0);
    for (int i = 0; i < 5; i++) sendBeat(32'h5000 + 32'(i));
    in_valid = 1'b1;
    reset = 1'b0;
    #1;
    check("midrst_ctrl", {busy, done, error, in_ready, out_valid, core_take, pm_write_en, dm_write_en}, 0);
    check("midrst_asm", dm_write_data, 0);
    dmBefore = dmWrites;
    step(); step();
    check("midrst_no_write", dmWrites, dmBefore);
    in_valid = 1'b0;
    reset = 1'b1;
    step();

    pmBefore = pmWrites;
    startJob(8'd200);
    for (int i = 0; i < 128; i++) sendBeat(32'hFFF00000 | 32'(i));
    check("clamp_writes", pmWrites - pmBefore, 128);
    check("pm127", pm[127], 20'd127);
    check("clamp_to_data", in_ready && busy, 1);
    loadData(32'h1000);
    runDrain(32'h1000, 1'b0);
    check("dm_row3_job2", dm[3], rowExp(32'h1000, 3));

`ifdef CAN_HOST_CTRL_TIMEOUT_EN
    begin
      int cyc = 0, early = 0;
      startJob(8'd0);
      loadData(32'h2000);
      core_halted = 1'b0;
      out_ready = 1'b1;
      while (!core_take && cyc < 100) begin step(); cyc++; end
      check("tmo_take", core_take, 1);
      for (int i = 1; i <= 20; i++) begin
        step();
        if (done || error || out_valid) early++;
      end
      check("tmo_early", early, 0);
      step();
      check("tmo_done_err", {done, error, out_valid}, 3'b110);
      step();
      check("tmo_idle", {busy, done, error}, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/can_host_ctrl.md
CAN_HOST_CTRL -- requirements
Module: can_host_ctrl

Interface
REQ-001 Parameters (name, default, meaning): PROG_DEPTH, 128, program memory words; DATA_ROWS, 16, data memory rows; TIMEOUT_CYCLES, 65535, run watchdog limit.
REQ-002 clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  begin a load/run/drain job; sampled only in IDLE.
REQ-005 prog_len  in  8  program words to load; 0 skips program load; values above 128 are clamped to 128.
REQ-006 in_valid/in_ready/in_data  in/out/in  1/1/32  host input stream; a beat transfers when in_valid and in_ready are both 1.
REQ-007 out_valid/out_ready/out_data  out/in/out  1/1/32  result stream; a beat transfers when out_valid and out_ready are both 1.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse when a job ends.
REQ-010 error  out  1  high with done when the job ended by timeout; low otherwise.
REQ-011 core_take  out  1  run pulse to the core.
REQ-012 core_halted  in  1  level from the core.
REQ-013 pm_write_en/pm_write_addr/pm_write_data  out  1/7/20  program memory write port.
REQ-014 dm_write_en/dm_write_addr/dm_write_data  out  1/4/512  data memory write port.
REQ-015 dm_read_addr/dm_read_data  out/in  4/512  data memory read port; read data is valid one cycle after the address is presented.

Function
REQ-016 The FSM SHALL have six states: IDLE, LOAD_PROG, LOAD_DATA, RUN, DRAIN, DONE.
REQ-017 IDLE + start: latch clamped prog_len; go to LOAD_PROG if prog_len is nonzero, else go to LOAD_DATA.
REQ-018 LOAD_PROG: in_ready=1; each beat writes in_data[19:0] to pm address 0,1,2,... in the same cycle (pm_write_en=1); in_data[31:20] ignored; after the prog_len-th beat go to LOAD_DATA.
REQ-019 LOAD_DATA: each beat k (0..15) fills bits [32k+31:32k] of a 512-bit assembly register; beat 15 also drives dm_write_en=1 for one cycle with the completed row, at row address 0..15.
REQ-020 After row 15 is written, go to RUN.
REQ-021 in_ready SHALL be 0 in every state except LOAD_PROG and LOAD_DATA, and SHALL be 0 in the cycle dm_write_en is asserted.
REQ-022 RUN: core_take=1 for exactly the first cycle only; core_halted ignored in that cycle and the next.
REQ-023 RUN, from the second cycle after take: the first cycle with core_halted=1 moves the FSM to DRAIN.
REQ-024 DRAIN: for rows 0..15 in order, present dm_read_addr, capture dm_read_data one cycle later, then emit 16 beats, word 0 (bits [31:0]) first.
REQ-025 out_valid SHALL remain high with out_data stable until the beat is accepted; a new row is not fetched until all 16 words of the current row are accepted.
REQ-026 After the last word of row 15 is accepted, go to DONE.
REQ-027 DONE: done=1 for one cycle, then go to IDLE; a start asserted in DONE is ignored.
REQ-028 start in any non-IDLE state SHALL be ignored.
REQ-029 Address counters SHALL never wrap: the program counter stops at prog_len-1 and the row counter at 15.

Reset
REQ-030 While reset=0: state=IDLE, all counters and the assembly register cleared, and every output (including write enables and core_take) driven 0.
REQ-031 Reset mid-job: memory contents already written are left unchanged; no further writes occur.

Configuration
REQ-032 With CAN_HOST_CTRL_TIMEOUT_EN defined: a 16-bit counter runs in RUN; if core_halted is not seen within TIMEOUT_CYCLES cycles of core_take, the FSM SHALL go to DONE with error=1 and skip DRAIN.
REQ-033 Without CAN_HOST_CTRL_TIMEOUT_EN: no counter is built, RUN waits indefinitely, and error is tied to 0.

Structure
REQ-034 Package can_ctrl_pkg SHALL hold: the state enum; widths 7 (program address), 20 (program word), 4 (row address), 512 (row), 32 (stream word); and WORDS_PER_ROW=16.
REQ-035 One sub-module, can_row_serdes, SHALL contain the 32-to-512 assembly and the 512-to-32 serialisation logic; the FSM lives in can_host_ctrl.

Verification
REQ-036 prog_len=3, beats 0xAAAAA/0x12345/0xFFFFF with upper bits set -> pm addresses 0..2 receive 0xAAAAA/0x12345/0xFFFFF.
REQ-037 256 data beats with value=index -> row r bits [32k+31:32k] equal 16r+k; dm_write_en fires exactly 16 times.
REQ-038 core_halted held 1 throughout -> core_take pulses once; DRAIN entered at the second cycle after take, not earlier.
REQ-039 out_ready toggled every other cycle during DRAIN -> 256 words in order, no loss or duplication; done pulses once with error=0.
REQ-040 TIMEOUT_EN defined, TIMEOUT_CYCLES=20, core_halted=0 -> done and error asserted together in cycle 21 after take; no out_valid.
REQ-041 reset=0 in LOAD_DATA after 5 beats -> all outputs 0 immediately; a fresh start then completes a full job normally.
